// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: handshake/data bundle for logic_unit_pipe.
//   master: upstream/downstream side (drives in_valid, a, b, op, out_ready)
//   slave : the pipeline (drives in_ready, out_valid, result, flags, out_pop,
//           op_count)
// WIDTH/COUNT_W must match the parameters of the attached logic_unit_pipe.
interface logic_unit_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  localparam int PW = $clog2(WIDTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               flag_zero;
  logic               flag_ones;
  logic [PW-1:0]      out_pop;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_ones, out_pop, op_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_ones, out_pop, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready pipeline applying a bitwise op
// (00 AND, 01 OR, 10 XOR, 11 NAND) to two WIDTH-bit operands.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : logic_unit_pipe_if.slave (in_valid/in_ready/a/b/op,
//                out_valid/out_ready/result/flag_zero/flag_ones/out_pop/op_count)
// Stage 1 registers operands; stage 2 registers result, flags and popcount.
// Build option: define LOGIC_UNIT_POPCOUNT_EN to compute out_pop; otherwise
// out_pop is tied to 0 and no popcount logic exists.

// One bit-lane of the bitwise op.
module logic_unit_lane (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  always_comb begin
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~(a & b);
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);
  // vld_pipe[1]: stage-1 holds operands; vld_pipe[2]: output stage valid
  logic [2:1]         vld_pipe;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [1:0]         s1_op;
  logic [WIDTH-1:0]   s2_res;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q, ones_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               s2_ready, in_fire, s2_load, out_fire;

  // Ready chain is purely from downstream state, never from in_valid.
  assign s2_ready = !vld_pipe[2] || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign s2_load  = vld_pipe[1] && s2_ready;
  assign out_fire = vld_pipe[2] && bus.out_ready;

  assign bus.in_ready  = !vld_pipe[1] || s2_ready;
  assign bus.out_valid = vld_pipe[2];
  assign bus.result    = res_q;
  assign bus.flag_zero = zero_q;
  assign bus.flag_ones = ones_q;
  assign bus.op_count  = cnt_q;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      logic_unit_lane u_lane (
        .a  (s1_a[i]),
        .b  (s1_b[i]),
        .op (s1_op),
        .y  (s2_res[i])
      );
    end
  endgenerate

  // Operand registers need no reset: they are only consumed behind vld_pipe[1].
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a  <= bus.a;
      s1_b  <= bus.b;
      s1_op <= bus.op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (in_fire)      vld_pipe[1] <= 1'b1;
      else if (s2_load) vld_pipe[1] <= 1'b0;

      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        res_q       <= s2_res;
        zero_q      <= (s2_res == '0);
        ones_q      <= (&s2_res);
      end else if (bus.out_ready) begin
        vld_pipe[2] <= 1'b0;
      end

      if (out_fire) cnt_q <= cnt_q + COUNT_W'(1);
    end
  end

`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  logic [PW-1:0] pop_nxt, pop_q;

  always_comb begin
    pop_nxt = '0;
    for (int k = 0; k < WIDTH; k++) pop_nxt = pop_nxt + PW'(s2_res[k]);
  end

  // Loaded alongside result so it shares latency and stall behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n)       pop_q <= '0;
    else if (s2_load) pop_q <= pop_nxt;
  end

  assign bus.out_pop = pop_q;
`else
  assign bus.out_pop = '0;
`endif
endmodule
